temp_sensor_reader: RTL and testbench

- SPI mode-0 master that periodically reads a serial digital temperature sensor.
- Converts the raw 13-bit signed reading (0.0625 °C/LSB) into the 16-bit unsigned deci-degree word (0.1 °C/LSB) consumed as temp_data by mainboard.
- Flags sensor faults so the alarm logic never acts on a bad frame.
- Sits between the board-level sensor pins and mainboard.

---
 rtl/temp_sensor_reader.sv | 161 ++++++++++++++++
 tb/tb_temp_sensor_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_sensor_reader.sv
// SPI mode-0 master that periodically reads a 13-bit serial temperature sensor
// and converts each good reading to an unsigned 0.1 degC word.
module temp_sensor_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        sensor_fault
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CONVERT} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] div_reg, div_next;
    logic [4:0]    edge_reg, edge_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [15:0]   shift_reg, shift_next;
    logic          sclk_reg, sclk_next;
    logic          cs_n_reg, cs_n_next;
    logic          done_reg, done_next;
    logic [15:0]   temp_data_reg, temp_data_next;
    logic          temp_valid_reg, temp_valid_next;
    logic          sensor_fault_reg, sensor_fault_next;

    logic          div_end;
    logic          frame_bad;
    logic [16:0]   product;
    logic [16:0]   product_shifted;
    logic [15:0]   converted;

    assign div_end = (div_reg == DW'(CLK_DIV - 1));

    // Negative readings clamp to zero; positive raw is at most 4095, so 17 bits never overflow.
    always_comb begin
        product         = 17'(shift_reg[14:3]) * 17'd10;
        product_shifted = product >> 4;
        converted       = shift_reg[15] ? 16'd0 : 16'(product_shifted);
        frame_bad       = shift_reg[2] | (shift_reg == 16'hFFFF);
    end

    always_comb begin
        state_next        = state_reg;
        div_next          = div_reg;
        edge_next         = edge_reg;
        timer_next        = (timer_reg == '0) ? '0 : timer_reg - 1'b1;
        shift_next        = shift_reg;
        sclk_next         = sclk_reg;
        cs_n_next         = cs_n_reg;
        done_next         = 1'b0;
        temp_data_next    = temp_data_reg;
        temp_valid_next   = 1'b0;
        sensor_fault_next = sensor_fault_reg;

        case (state_reg)
            IDLE: begin
                cs_n_next = 1'b1;
                sclk_next = 1'b0;
                if (enable && timer_reg == '0) begin
                    state_next = CS_SETUP;
                    cs_n_next  = 1'b0;
                    div_next   = '0;
                    timer_next = TW'(SAMPLE_PERIOD - 1);
                end
            end
            CS_SETUP: begin
                if (div_end) begin
                    div_next   = '0;
                    state_next = SHIFT;
                    sclk_next  = 1'b1;
                    shift_next = {shift_reg[14:0], miso};
                    edge_next  = 5'd1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    edge_next = edge_reg + 5'd1;
                    if (!sclk_reg)
                        shift_next = {shift_reg[14:0], miso};
                    // edge_reg counts completed sclk edges; this is the 32nd, a falling edge
                    if (edge_reg == 5'd31)
                        state_next = CS_HOLD;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            CS_HOLD: begin
                if (div_end) begin
                    div_next   = '0;
                    cs_n_next  = 1'b1;
                    state_next = CONVERT;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            CONVERT: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (done_reg) begin
            if (frame_bad) begin
                sensor_fault_next = 1'b1;
            end else begin
                sensor_fault_next = 1'b0;
                temp_valid_next   = 1'b1;
                temp_data_next    = converted;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            div_reg          <= '0;
            edge_reg         <= '0;
            timer_reg        <= '0;
            shift_reg        <= '0;
            sclk_reg         <= 1'b0;
            cs_n_reg         <= 1'b1;
            done_reg         <= 1'b0;
            temp_data_reg    <= '0;
            temp_valid_reg   <= 1'b0;
            sensor_fault_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            div_reg          <= div_next;
            edge_reg         <= edge_next;
            timer_reg        <= timer_next;
            shift_reg        <= shift_next;
            sclk_reg         <= sclk_next;
            cs_n_reg         <= cs_n_next;
            done_reg         <= done_next;
            temp_data_reg    <= temp_data_next;
            temp_valid_reg   <= temp_valid_next;
            sensor_fault_reg <= sensor_fault_next;
        end
    end

    assign sclk         = sclk_reg;
    assign cs_n         = cs_n_reg;
    assign temp_data    = temp_data_reg;
    assign temp_valid   = temp_valid_reg;
    assign sensor_fault = sensor_fault_reg;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader: a behavioural sensor shifts out a
// programmed 16-bit frame, and each step checks against hand-computed results.
module tb_temp_sensor_reader;

    localparam int CD = 4;
    localparam int SP = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        miso;
    logic        sclk;
    logic        cs_n;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        sensor_fault;

    int tests = 0;
    int fails = 0;

    temp_sensor_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .miso         (miso),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .temp_data    (temp_data),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    // Sensor model: presents the MSB while cs_n is high, advances on each sclk fall.
    logic [15:0] sensor_word = 16'h0000;
    int          bit_idx     = 15;
    always @(posedge cs_n or negedge sclk) begin
        if (cs_n)
            bit_idx = 15;
        else if (bit_idx > 0)
            bit_idx = bit_idx - 1;
    end
    always_comb miso = sensor_word[bit_idx];

    // Monitor sampled on the falling clk edge.
    int cyc = 0, fall_cnt = 0, last_fall_cyc = 0, fall_gap = 0;
    int rise_cnt = 0, valid_cnt = 0, cs_rise_cyc = 0, valid_cyc = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_cs === 1'b1 && cs_n === 1'b0) begin
            fall_cnt      = fall_cnt + 1;
            fall_gap      = cyc - last_fall_cyc;
            last_fall_cyc = cyc;
            rise_cnt      = 0;
            valid_cnt     = 0;
        end
        if (prev_cs === 1'b0 && cs_n === 1'b1) cs_rise_cyc = cyc;
        if (prev_sclk === 1'b0 && sclk === 1'b1) rise_cnt = rise_cnt + 1;
        if (temp_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cs(input logic level, input int limit, input string tag);
        int k;
        k = 0;
        while (cs_n !== level && k < limit) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, cs_n === level}, 32'd1);
    endtask

    // Run one full frame carrying word, ending a few cycles after temp_valid would pulse.
    task automatic frame(input logic [15:0] word, input string tag);
        sensor_word = word;
        wait_cs(1'b0, SP + 20, {tag, "_start"});
        wait_cs(1'b1, 40 * CD + 20, {tag, "_end"});
        tick(4);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        sensor_word = 16'h0F00;
        tick(3);
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_data", {16'd0, temp_data}, 32'd0);
        chk("rst_valid", {31'd0, temp_valid}, 32'd0);
        chk("rst_fault", {31'd0, sensor_fault}, 32'd0);

        reset = 1'b1;
        tick(1);
        chk("first_cs_fall", {31'd0, cs_n}, 32'd0);
        frame(16'h0F00, "f30");
        chk("f30_rises", rise_cnt, 32'd16);
        chk("f30_valid_cnt", valid_cnt, 32'd1);
        chk("f30_latency", valid_cyc - cs_rise_cyc, 32'd2);
        chk("f30_data", {16'd0, temp_data}, 32'd300);
        chk("f30_fault", {31'd0, sensor_fault}, 32'd0);

        frame(16'h1E00, "f60");
        chk("f60_period", fall_gap, SP);
        chk("f60_data", {16'd0, temp_data}, 32'd600);
        chk("f60_valid_cnt", valid_cnt, 32'd1);

        frame(16'hFB00, "fneg");
        chk("fneg_data", {16'd0, temp_data}, 32'd0);
        chk("fneg_valid_cnt", valid_cnt, 32'd1);

        frame(16'h0040, "fraw8");
        chk("fraw8_data", {16'd0, temp_data}, 32'd5);

        frame(16'h0008, "fraw1");
        chk("fraw1_data", {16'd0, temp_data}, 32'd0);
        chk("fraw1_valid_cnt", valid_cnt, 32'd1);

        frame(16'h0F00, "fgood");
        chk("fgood_data", {16'd0, temp_data}, 32'd300);

        frame(16'h0F04, "fbit2");
        chk("fbit2_fault", {31'd0, sensor_fault}, 32'd1);
        chk("fbit2_valid_cnt", valid_cnt, 32'd0);
        chk("fbit2_data", {16'd0, temp_data}, 32'd300);

        frame(16'h0F00, "frecover");
        chk("frecover_fault", {31'd0, sensor_fault}, 32'd0);
        chk("frecover_valid_cnt", valid_cnt, 32'd1);

        frame(16'hFFFF, "fstuck");
        chk("fstuck_fault", {31'd0, sensor_fault}, 32'd1);
        chk("fstuck_valid_cnt", valid_cnt, 32'd0);
        chk("fstuck_data", {16'd0, temp_data}, 32'd300);

        // Reset partway through a frame.
        sensor_word = 16'h1E00;
        wait_cs(1'b0, SP + 20, "midrst_start");
        begin
            int k;
            k = 0;
            while (rise_cnt < 8 && k < 40 * CD) begin
                tick(1);
                k++;
            end
        end
        chk("midrst_rises", rise_cnt, 32'd8);
        reset = 1'b0;
        #1;
        chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk}, 32'd0);
        chk("midrst_data", {16'd0, temp_data}, 32'd0);
        chk("midrst_fault", {31'd0, sensor_fault}, 32'd0);
        tick(5);
        enable = 1'b0;
        reset  = 1'b1;
        tick(2 * 40 * CD);
        chk("midrst_no_valid", valid_cnt, 32'd0);
        chk("midrst_data_hold", {16'd0, temp_data}, 32'd0);

        // Drop enable mid-frame: the frame finishes, then no further frame starts.
        enable = 1'b1;
        sensor_word = 16'h0040;
        wait_cs(1'b0, SP + 20, "endis_start");
        tick(10);
        enable = 1'b0;
        wait_cs(1'b1, 40 * CD + 20, "endis_end");
        tick(4);
        chk("endis_valid_cnt", valid_cnt, 32'd1);
        chk("endis_data", {16'd0, temp_data}, 32'd5);
        begin
            int falls_before;
            falls_before = fall_cnt;
            tick(SP + 50);
            chk("endis_no_new_frame", fall_cnt - falls_before, 32'd0);
            chk("endis_cs_idle", {31'd0, cs_n}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
